// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings for mult/multu/div/divu
//   - control FSM state type
//   - small op-decoding helpers
package multdiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_mul(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate. Used both to take magnitudes of
// signed operands at capture and to restore result signs in FIX.
//   val_i  operand
//   neg_i  1 = output -val_i, 0 = pass through
//   val_o  result
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (neg_i) val_o = ~val_i + WIDTH'(1);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; signs are restored in a final FIX cycle.
//   clk, reset(async, active-low)
//   start/op/a/b : request, sampled in IDLE only
//   busy         : accepting edge until done edge
//   done         : one-cycle pulse, hi/lo valid
//   div_zero     : one-cycle pulse with done for a divide by zero
//   hi/lo        : architectural HI/LO registers
// Optional: define MULTDIV_EARLY_TERM_EN to leave MUL once the remaining
// multiplier bits are all zero.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;       // product, or {remainder, quotient/dividend}
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, or divisor
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dzp_q, dzp_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix, div_diff;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic             mul_last;

  assign signed_op = op_is_signed(op);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .val_i(a), .neg_i(signed_op & a[WIDTH-1]), .val_o(abs_a)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .val_i(b), .neg_i(signed_op & b[WIDTH-1]), .val_o(abs_b)
  );
  mdu_sign_fix #(.WIDTH(PW)) u_fix_prod (
    .val_i(acc_q), .neg_i(neg_res_q), .val_o(prod_fix)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_fix)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i(acc_q[PW-1:WIDTH]), .neg_i(neg_rem_q), .val_o(rem_fix)
  );

  // Restoring step: partial remainder shifted left with the next dividend
  // bit. The remainder stays below the divisor, so the difference fits WIDTH.
  assign div_shift = acc_q[PW-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, mplier_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mplier_q;

`ifdef MULTDIV_EARLY_TERM_EN
  assign mul_last = (cnt_q == CNT_W'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt_q == CNT_W'(1));
`endif

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dzp_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d  = op_is_div(op);
          neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_op & a[WIDTH-1];
          dz_d      = op_is_div(op) && (b == '0);
          cnt_d     = CNT_W'(WIDTH);
          mcand_d   = {{WIDTH{1'b0}}, abs_a};
          acc_d     = op_is_div(op) ? {{WIDTH{1'b0}}, abs_a} : '0;
          mplier_d  = abs_b;
          busy_d    = 1'b1;
          if (op_is_mul(op))  state_d = ST_MUL;
          else if (b == '0)   state_d = ST_FIX;
          else                state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (mul_last) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dzp_d   = dz_q;
        state_d = ST_IDLE;
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dzp_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dzp_q     <= dzp_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzp_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the multicycle MIPS core.
- Executes mult, multu, div and divu, and owns the architectural HI/LO registers read by mfhi/mflo through the MemToReg mux.
- Control FSM pulses `start` for one cycle, holds in a wait state while `busy`=1, and resumes on `done`.
- Operands come from the A and B registers.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH each.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00=mult, 01=multu, 10=div, 11=divu; sampled with start.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- busy  out  1  high from the accepting edge until the done edge.
- done  out  1  one-cycle pulse; HI/LO valid in the same cycle.
- div_zero  out  1  one-cycle pulse with done, for a div/divu with b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- One clock: clk. reset is asynchronous and active-low.
  - reset=0 forces state=IDLE and busy=done=div_zero=0.
  - It also forces hi=lo=0 and clears the counter, regardless of clk.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 at edge E0 captures |a|, |b| (magnitudes for signed ops, raw values for unsigned), the result-sign flags and op.
  - Then: → MUL for op 0x; → DIV for op 1x; busy=1.
- Divide by zero (op 1x with b==0):
  - At E0 go to FIX with the div_zero flag set instead of entering DIV.
  - At E1: done=1, div_zero=1, hi/lo unchanged.
- MUL: shift-add, one multiplier bit per cycle, accumulating a 2*WIDTH-bit product. Exactly WIDTH iterations (E1..E_WIDTH), then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH iterations, then FIX.
- FIX (one cycle):
  - Applies two's-complement negation where required.
  - Product: negated if sign(a)≠sign(b) and op=mult.
  - Quotient: negated if the signs differ and op=div.
  - Remainder: takes the sign of the dividend.
  - Mult: hi=upper WIDTH bits, lo=lower WIDTH bits.
  - Div: hi=remainder, lo=quotient.
  - Writes hi/lo; done=1 and busy=0 at that edge; → IDLE.
- Latency: done is observed after edge E0+WIDTH+1 (33 cycles at WIDTH=32). hi/lo hold their previous values until then.
- Signed overflow: div MIN/−1 gives lo=MIN (wrapped), hi=0, no exception flag.
- start while busy=1: ignored, no effect on the operation in flight.
- Back-to-back: start may be asserted in the cycle done=1 (FSM is already in IDLE). It is accepted at the next edge.
- a/b may change after E0 without effect.

Optional Feature:
- Macro: MULTDIV_EARLY_TERM_EN.
- Defined: MUL leaves for FIX as soon as the remaining (shifted) multiplier magnitude is zero.
  - Minimum multiply latency: E0+2 (b==0 or b==1 magnitude).
  - Results are identical to the non-early path.
  - DIV latency is unchanged.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor operations.

Decomposition:
- Shared package multdiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state typedef / localparams (IDLE, MUL, DIV, FIX).
  - Control FSM imports the op encodings.
- One natural sub-module, mdu_sign_fix:
  - Combinational magnitude/negate helper.
  - Used at capture (abs) and in FIX (conditional negate).
  - Parametrised by WIDTH; instantiated for the 2*WIDTH product as well.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after start; busy high in between.
- mult a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- divu a=5, b=0 with prior hi/lo=0x11/0x22 → done and div_zero pulse one cycle after start; hi=0x11, lo=0x22.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. A second start asserted during busy is ignored; a start asserted in the done cycle is accepted next edge.
- Assert reset=0 mid-MUL at cycle 10, between clock edges → busy, done, hi, lo go to 0 immediately. After release, a new mult of 6×7 gives lo=42, hi=0.
